// File: rtl/data_memory_sized.sv
// Sized RISC-V data memory (LB/LH/LW/LBU/LHU, SB/SH/SW) behind a one-outstanding
// request/response handshake with a configurable read latency.
//
// Ports
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous reset, active-low
//   req_valid   in   request present
//   req_ready   out  request can be accepted (IDLE only)
//   MemRead     in   request is a load
//   MemWrite    in   request is a store
//   funct3      in   size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   endereco    in   byte address
//   write_data  in   store data, LSB-aligned
//   resp_valid  out  one-cycle response strobe
//   read_data   out  extended load data, zero outside the response
//   erro        out  access fault flag, zero outside the response
module data_memory_sized #(
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] endereco,
    input  logic [31:0]           write_data,
    output logic                  resp_valid,
    output logic [31:0]           read_data,
    output logic                  erro
);

    localparam int unsigned IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned WADDR_W   = ADDR_WIDTH - 2;
    localparam int unsigned CNT_W     = 2;
    localparam int unsigned WAIT_LAST = (LATENCY > 1) ? LATENCY - 2 : 0;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_WAIT = 2'b01,
        S_RESP = 2'b10
    } state_t;

    // Request context captured at the accept edge and held until the response.
    typedef struct packed {
        logic [31:0] word;
        logic [2:0]  f3;
        logic [1:0]  lane;
        logic        fault;
        logic        load;
    } held_t;

    logic [31:0] mem [DEPTH];

    state_t             state_q, state_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n;
    held_t              held_q;

    logic               ready_n;
    logic               resp_n;
    logic [31:0]        rdata_n;
    logic               erro_n;

    logic               accept;
    logic [IDX_W-1:0]   word_idx;
    logic               legal_ld;
    logic               legal_st;
    logic               op_bad;
    logic               f3_bad;
    logic               align_bad;
    logic               range_bad;
    logic               fault;
    logic               we;
    logic [3:0]         be;
    logic [31:0]        wdata_rep;
    logic [31:0]        live_word;

    logic [31:0]        src_word;
    logic [2:0]         src_f3;
    logic [1:0]         src_lane;
    logic               src_fault;
    logic               src_load;

    assign accept   = req_valid & req_ready;
    assign word_idx = endereco[IDX_W+1:2];

    // Request legality checks.
    always_comb begin
        legal_ld  = (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
        legal_st  = (funct3 == F3_B)  || (funct3 == F3_H)  || (funct3 == F3_W);
        op_bad    = (MemRead == MemWrite);
        f3_bad    = MemRead ? !legal_ld : !legal_st;
        align_bad = ((funct3[1:0] == 2'b01) && endereco[0]) ||
                    ((funct3 == F3_W) && (endereco[1:0] != 2'b00));
        range_bad = ({1'b0, endereco[ADDR_WIDTH-1:2]} >= (WADDR_W + 1)'(DEPTH));
        fault     = op_bad | f3_bad | align_bad | range_bad;
    end

    // Byte-lane enables and lane-replicated store data.
    always_comb begin
        be        = 4'b0000;
        wdata_rep = write_data;
        case (funct3[1:0])
            2'b00: begin
                be        = 4'b0001 << endereco[1:0];
                wdata_rep = {4{write_data[7:0]}};
            end
            2'b01: begin
                be        = endereco[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{write_data[15:0]}};
            end
            2'b10: begin
                be        = 4'b1111;
                wdata_rep = write_data;
            end
            default: begin
                be        = 4'b0000;
                wdata_rep = write_data;
            end
        endcase
    end

    assign we        = accept & MemWrite & ~fault;
    assign live_word = mem[word_idx];

    // Storage array; not cleared by reset, stores commit at the accept edge.
    always_ff @(posedge clock) begin
        if (we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[word_idx][8*b +: 8] <= wdata_rep[8*b +: 8];
                end
            end
        end
    end

    // Load extension for the selected lane.
    function automatic logic [31:0] extend(input logic [31:0] word,
                                           input logic [2:0]  f3,
                                           input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        case (f3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    result = word;
            F3_BU:   result = {24'h000000, shifted[7:0]};
            F3_HU:   result = {16'h0000, shifted[15:0]};
            default: result = 32'h0000_0000;
        endcase
        return result;
    endfunction

    // With LATENCY==1 the response is produced on the accept edge itself, so the
    // live request feeds the output registers; otherwise the held copy does.
    always_comb begin
        if (state_q == S_IDLE) begin
            src_word  = live_word;
            src_f3    = funct3;
            src_lane  = endereco[1:0];
            src_fault = fault;
            src_load  = MemRead & ~fault;
        end else begin
            src_word  = held_q.word;
            src_f3    = held_q.f3;
            src_lane  = held_q.lane;
            src_fault = held_q.fault;
            src_load  = held_q.load;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        ready_n = 1'b0;
        resp_n  = 1'b0;
        rdata_n = 32'h0000_0000;
        erro_n  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_n = '0;
                if (accept) begin
                    state_n = (LATENCY > 1) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(WAIT_LAST)) begin
                    state_n = S_RESP;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
            end
        endcase

        ready_n = (state_n == S_IDLE);
        resp_n  = (state_n == S_RESP);
        if (state_n == S_RESP) begin
            erro_n  = src_fault;
            rdata_n = src_load ? extend(src_word, src_f3, src_lane) : 32'h0000_0000;
        end
    end

    // State, counter, held request and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            held_q     <= '0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            read_data  <= 32'h0000_0000;
            erro       <= 1'b0;
        end else begin
            state_q    <= state_n;
            cnt_q      <= cnt_n;
            req_ready  <= ready_n;
            resp_valid <= resp_n;
            read_data  <= rdata_n;
            erro       <= erro_n;
            if (accept) begin
                held_q.word  <= live_word;
                held_q.f3    <= funct3;
                held_q.lane  <= endereco[1:0];
                held_q.fault <= fault;
                held_q.load  <= MemRead & ~fault;
            end
        end
    end

endmodule

// File: tb/tb_data_memory_sized.sv
// Scoreboard bench for data_memory_sized: one LATENCY=1 and one LATENCY=3 instance.
module tb_data_memory_sized;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

    typedef struct {
        int          u;
        logic [31:0] data;
        logic        err;
        int          acc;
        string       tag;
    } exp_t;

    logic             clock = 1'b0;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       mem_read;
    logic [1:0]       mem_write;
    logic [1:0][2:0]  f3;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wdata;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] read_data;
    logic [1:0]       erro;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          cyc      = 0;
    bit          mon_en   = 1'b0;
    exp_t        sbq[$];
    logic [31:0] mref [2][256];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    data_memory_sized #(.DEPTH(256), .ADDR_WIDTH(32), .LATENCY(1)) dut0 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .MemRead(mem_read[0]), .MemWrite(mem_write[0]),
        .funct3(f3[0]), .endereco(addr[0]), .write_data(wdata[0]),
        .resp_valid(resp_valid[0]), .read_data(read_data[0]), .erro(erro[0])
    );

    data_memory_sized #(.DEPTH(256), .ADDR_WIDTH(32), .LATENCY(3)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .MemRead(mem_read[1]), .MemWrite(mem_write[1]),
        .funct3(f3[1]), .endereco(addr[1]), .write_data(wdata[1]),
        .resp_valid(resp_valid[1]), .read_data(read_data[1]), .erro(erro[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    function automatic int lat_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Reference model: returns the expected response and applies stores.
    function automatic exp_t model(input int u, input logic rd, input logic wr,
                                   input logic [2:0] fn, input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t        e;
        logic [31:0] w;
        int          idx;
        int          sh;
        bit          bad;
        e.u = u; e.data = 32'h0; e.err = 1'b0; e.acc = 0; e.tag = "";
        bad = (rd == wr);
        if (rd && !(fn inside {LB, LH, LW, LBU, LHU})) bad = 1'b1;
        if (wr && !(fn inside {LB, LH, LW})) bad = 1'b1;
        if ((fn == LH || fn == LHU) && a[0]) bad = 1'b1;
        if (fn == LW && a[1:0] != 2'b00) bad = 1'b1;
        if (a >= 32'd1024) bad = 1'b1;
        e.err = bad;
        if (bad) return e;
        idx = int'(a[9:2]);
        sh  = 8 * int'(a[1:0]);
        w   = mref[u][idx];
        if (wr) begin
            case (fn)
                LB:      w[sh +: 8]  = wd[7:0];
                LH:      w[sh +: 16] = wd[15:0];
                default: w = wd;
            endcase
            mref[u][idx] = w;
        end else begin
            case (fn)
                LB:      e.data = {{24{w[sh+7]}}, w[sh +: 8]};
                LBU:     e.data = {24'h0, w[sh +: 8]};
                LH:      e.data = {{16{w[sh+15]}}, w[sh +: 16]};
                LHU:     e.data = {16'h0, w[sh +: 16]};
                default: e.data = w;
            endcase
        end
        return e;
    endfunction

    // Response monitor: pops the scoreboard on each strobe, checks idle outputs otherwise.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            for (int u = 0; u < 2; u++) begin
                if (resp_valid[u]) begin
                    if (sbq.size() == 0 || sbq[0].u != u) begin
                        chk("unexpected_resp", 32'(resp_valid[u]), 32'd0);
                    end else begin
                        e = sbq.pop_front();
                        chk({e.tag, "_data"}, read_data[u], e.data);
                        chk({e.tag, "_err"}, 32'(erro[u]), 32'(e.err));
                        chk({e.tag, "_lat"}, 32'(cyc - e.acc), 32'(lat_of(u)));
                    end
                end else begin
                    chk("idle_data", read_data[u], 32'd0);
                    chk("idle_err", 32'(erro[u]), 32'd0);
                end
            end
        end
    end

    task automatic set_req(input int u, input logic rd, input logic wr,
                           input logic [2:0] fn, input logic [31:0] a, input logic [31:0] wd);
        mem_read[u]  = rd;
        mem_write[u] = wr;
        f3[u]        = fn;
        addr[u]      = a;
        wdata[u]     = wd;
    endtask

    task automatic wait_ready(input int u, input string tag);
        int n = 0;
        while (!req_ready[u] && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready[u]) chk({tag, "_ready_timeout"}, 32'(req_ready[u]), 32'd1);
    endtask

    // Single request, then wait for its response to drain from the scoreboard.
    task automatic req(input int u, input logic rd, input logic wr, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] wd, input string tag);
        exp_t e;
        int   n;
        @(negedge clock);
        wait_ready(u, tag);
        set_req(u, rd, wr, fn, a, wd);
        req_valid[u] = 1'b1;
        e     = model(u, rd, wr, fn, a, wd);
        e.acc = cyc;
        e.tag = tag;
        sbq.push_back(e);
        @(posedge clock);
        #1 req_valid[u] = 1'b0;
        n = 0;
        while (sbq.size() != 0 && n < 20) begin
            @(negedge clock);
            n++;
        end
        #1;
        if (sbq.size() != 0) begin
            chk({tag, "_resp_timeout"}, 32'(sbq.size()), 32'd0);
            sbq.delete();
        end
    endtask

    // Back-to-back loads on the LATENCY=3 instance with req_valid held high.
    task automatic burst();
        logic [31:0] ba [4];
        logic [2:0]  bf [4];
        exp_t        e;
        int          n;
        ba[0] = 32'h20; bf[0] = LW;
        ba[1] = 32'h21; bf[1] = LB;
        ba[2] = 32'h2E; bf[2] = LHU;
        ba[3] = 32'h24; bf[3] = LW;
        @(negedge clock);
        wait_ready(1, "b2b");
        req_valid[1] = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_req(1, 1'b1, 1'b0, bf[k], ba[k], 32'h0);
            e     = model(1, 1'b1, 1'b0, bf[k], ba[k], 32'h0);
            e.acc = cyc;
            e.tag = $sformatf("b2b%0d", k);
            sbq.push_back(e);
            @(posedge clock);
            n = 0;
            @(negedge clock);
            while (!req_ready[1] && n < 10) begin
                n++;
                @(negedge clock);
            end
            if (k == 3) req_valid[1] = 1'b0;
            chk($sformatf("b2b%0d_busy", k), 32'(n), 32'd3);
        end
        repeat (2) @(negedge clock);
        chk("b2b_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        reset_n   = 1'b1;
        req_valid = '0;
        mem_read  = '0;
        mem_write = '0;
        f3        = '0;
        addr      = '0;
        wdata     = '0;
        for (int u = 0; u < 2; u++)
            for (int i = 0; i < 256; i++) mref[u][i] = 32'h0;
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("rst_ready%0d", u), 32'(req_ready[u]), 32'd1);
            chk($sformatf("rst_resp%0d", u), 32'(resp_valid[u]), 32'd0);
            chk($sformatf("rst_data%0d", u), read_data[u], 32'd0);
            chk($sformatf("rst_err%0d", u), 32'(erro[u]), 32'd0);
        end
        @(negedge clock);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        // LATENCY=1: basic, sized and faulting accesses.
        req(0, 0, 1, LW,  32'h10,  32'hDEADBEEF, "sw10");
        req(0, 1, 0, LW,  32'h10,  32'h0,        "lw10");
        req(0, 0, 1, LB,  32'h11,  32'h00000080, "sb11");
        req(0, 1, 0, LB,  32'h11,  32'h0,        "lb11");
        req(0, 1, 0, LBU, 32'h11,  32'h0,        "lbu11");
        req(0, 1, 0, LW,  32'h10,  32'h0,        "lw10_b");
        req(0, 0, 1, LH,  32'h12,  32'h00001234, "sh12");
        req(0, 1, 0, LH,  32'h12,  32'h0,        "lh12");
        req(0, 1, 0, LH,  32'h13,  32'h0,        "lh13_mis");
        req(0, 1, 0, LW,  32'h10,  32'h0,        "lw10_c");
        req(0, 0, 1, LW,  32'h00,  32'h11223344, "sw00");
        req(0, 0, 1, LW,  32'h400, 32'hFFFFFFFF, "sw400_oor");
        req(0, 1, 0, LW,  32'h00,  32'h0,        "lw00");
        req(0, 1, 0, 3'b011, 32'h10, 32'h0,      "ld_f3_011");
        req(0, 1, 1, LW,  32'h10,  32'h0,        "rd_wr_both");
        req(0, 0, 0, LW,  32'h10,  32'h0,        "rd_wr_none");
        req(0, 0, 1, 3'b100, 32'h10, 32'h0,      "st_f3_100");
        req(0, 0, 1, LH,  32'h11,  32'h0,        "sh11_mis");
        req(0, 1, 0, LW,  32'h12,  32'h0,        "lw12_mis");
        req(0, 1, 0, LW,  32'h10,  32'h0,        "lw10_d");
        req(0, 0, 1, LW,  32'h14,  32'h0,        "sw14");
        req(0, 0, 1, LH,  32'h16,  32'h0000F00D, "sh16");
        req(0, 1, 0, LH,  32'h16,  32'h0,        "lh16");
        req(0, 1, 0, LHU, 32'h16,  32'h0,        "lhu16");
        req(0, 0, 1, LW,  32'h18,  32'h0,        "sw18");
        for (int k = 0; k < 4; k++)
            req(0, 0, 1, LB, 32'h18 + 32'(k), 32'hA0 + 32'(k), $sformatf("sb18_%0d", k));
        req(0, 1, 0, LW,  32'h18,  32'h0,        "lw18");
        req(0, 1, 0, LB,  32'h1B,  32'h0,        "lb1b");

        // LATENCY=3: stores, then back-to-back loads.
        req(1, 0, 1, LW,  32'h20,  32'hCAFEF00D, "l3_sw20");
        req(1, 0, 1, LW,  32'h24,  32'h01234567, "l3_sw24");
        req(1, 0, 1, LW,  32'h2C,  32'h9ABC0000, "l3_sw2c");
        req(1, 1, 0, LW,  32'h20,  32'h0,        "l3_lw20");
        burst();

        // Reset during WAIT drops the pending response but keeps committed stores.
        @(negedge clock);
        wait_ready(1, "rst_mid");
        set_req(1, 1'b1, 1'b0, LW, 32'h20, 32'h0);
        req_valid[1] = 1'b1;
        @(posedge clock);
        #1 req_valid[1] = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy", 32'(req_ready[1]), 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(req_ready[1]), 32'd1);
        chk("rst_mid_resp", 32'(resp_valid[1]), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (6) @(negedge clock);
        req(1, 1, 0, LW,  32'h20,  32'h0,        "rst_lw20");
        req(0, 1, 0, LW,  32'h18,  32'h0,        "rst_lw18");

        repeat (3) @(negedge clock);
        chk("sb_empty", 32'(sbq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
